// File: rtl/cabac_bit_fetcher.sv
// cabac_bit_fetcher: MSB-first bit buffer between a byte stream source and the arithmetic decoder.
// Serves 1..MAX_RD bit reads, byte alignment and zero-padded reads past end of stream.
module cabac_bit_fetcher #(
  parameter int BUF_W  = 32,
  parameter int MAX_RD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_req,
  input  logic              rd_req,
  input  logic [4:0]        rd_num,
  input  logic              align_req,
  output logic [MAX_RD-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_pad,
  output logic [31:0]       bit_pos,
  output logic              eos
);
  localparam int CW = $clog2(BUF_W + 1);
  logic [BUF_W-1:0]  buf_q, shifted;
  logic [CW-1:0]     count, n, r, sh, cnt_sh;
  logic [MAX_RD-1:0] top;
  logic              seen, align_pend, align_act, align_go, rd_go, take;
  assign byte_req = (count <= CW'(BUF_W - 8)) && !eos;
  assign top      = buf_q[BUF_W-1 -: MAX_RD];
  always_comb begin
    n         = (rd_num == 5'd0 || 32'(rd_num) > MAX_RD) ? CW'(MAX_RD) : CW'(rd_num);
    r         = (bit_pos[2:0] == 3'd0) ? '0 : CW'(4'd8 - {1'b0, bit_pos[2:0]});
    align_act = align_req || align_pend;
    align_go  = align_act && (count >= r || eos);
    rd_go     = rd_req && !rd_valid && !align_act && (count >= n || eos);
    sh        = align_go ? r : rd_go ? n : '0;
    cnt_sh    = (count >= sh) ? count - sh : '0;
    shifted   = buf_q << sh;
    take      = byte_req && byte_valid;
  end
  // Shift-out happens first; the incoming byte lands directly below the surviving bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      count      <= '0;
      bit_pos    <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_pad     <= 1'b0;
      eos        <= 1'b0;
      seen       <= 1'b0;
      align_pend <= 1'b0;
    end else begin
      buf_q      <= take ? shifted | ({byte_in, {(BUF_W-8){1'b0}}} >> cnt_sh) : shifted;
      count      <= take ? cnt_sh + CW'(8) : cnt_sh;
      bit_pos    <= bit_pos + 32'(sh);
      seen       <= seen || take;
      eos        <= eos || (seen && !byte_valid);
      align_pend <= align_act && !align_go;
      rd_valid   <= rd_go;
      if (rd_go) begin
        rd_data <= top >> (CW'(MAX_RD) - n);
        rd_pad  <= count < n;
      end
    end
  end
  a_rd_num_legal: assert property (@(posedge clk) disable iff (!rst_n)
    rd_req |-> (rd_num != 5'd0 && 32'(rd_num) <= MAX_RD));
endmodule

// File: tb/tb_cabac_bit_fetcher.sv
// tb_cabac_bit_fetcher: directed and randomized checks of cabac_bit_fetcher against a bit-stream model.
module tb_cabac_bit_fetcher;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in;
  logic        byte_valid, byte_req;
  logic        rd_req = 1'b0;
  logic [4:0]  rd_num = 5'd1;
  logic        align_req = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid, rd_pad, eos;
  logic [31:0] bit_pos;

  logic [7:0] src [0:255];
  int         src_len = 0;
  int         src_idx = 0;
  logic       src_en = 1'b0;
  int         checks = 0;
  int         failures = 0;
  int         base = 0;
  int         mpos = 0;

  always #5 clk = ~clk;

  assign byte_valid = src_en && (src_idx < src_len);
  assign byte_in    = byte_valid ? src[8'(src_idx)] : 8'h00;

  // Upstream source: advances only when the fetcher actually takes a byte; it has no reset.
  always @(posedge clk) if (rst_n && byte_req && byte_valid) src_idx <= src_idx + 1;

  cabac_bit_fetcher #(.BUF_W(32), .MAX_RD(16)) dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid), .byte_req(byte_req),
    .rd_req(rd_req), .rd_num(rd_num), .align_req(align_req), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_pad(rd_pad), .bit_pos(bit_pos), .eos(eos)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_bits(input int p, input int n);
    logic [15:0] v = '0;
    for (int i = 0; i < n; i++) begin
      int b = base + p + i;
      v = {v[14:0], (b / 8 < src_len) ? src[b / 8][7 - (b % 8)] : 1'b0};
    end
    return v;
  endfunction

  task automatic release_dut();
    rd_req = 1'b0;
    align_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base = src_idx * 8;
    mpos = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int n, input string tag, output logic [15:0] got);
    logic [15:0] ed;
    logic        ep;
    int          k;
    ed = ref_bits(mpos, n);
    ep = (base + mpos + n) > src_len * 8;
    rd_num = 5'(n);
    rd_req = 1'b1;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!rd_valid && k < 500);
    rd_req = 1'b0;
    got = rd_data;
    mpos += n;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"}, 32'(rd_data), 32'(ed));
    check({tag, "_pad"}, 32'(rd_pad), 32'(ep));
    check({tag, "_bitpos"}, bit_pos, 32'(mpos));
  endtask

  task automatic do_align(input string tag);
    int k;
    align_req = 1'b1;
    @(posedge clk);
    #1;
    align_req = 1'b0;
    mpos = (mpos + 7) / 8 * 8;
    k = 0;
    while (bit_pos !== 32'(mpos) && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_bitpos"}, bit_pos, 32'(mpos));
  endtask

  initial begin
    logic [15:0] d;
    logic        saw_valid;
    int          first_byte;
    // Reset state
    src_len = 1; src[0] = 8'h5A; src_idx = 0; src_en = 1'b0;
    #1;
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_pad", 32'(rd_pad), 0);
    check("rst_bit_pos", bit_pos, 0);
    check("rst_eos", 32'(eos), 0);
    release_dut();
    check("idle_byte_req", 32'(byte_req), 1);
    // Stall before first byte is not end of stream
    rd_num = 5'd8;
    rd_req = 1'b1;
    saw_valid = 1'b0;
    repeat (50) begin
      @(posedge clk);
      #1;
      saw_valid |= rd_valid;
    end
    check("stall_no_valid", 32'(saw_valid), 0);
    check("stall_eos", 32'(eos), 0);
    src_en = 1'b1;
    @(posedge clk);
    #1;
    check("stall_take_novalid", 32'(rd_valid), 0);
    @(posedge clk);
    #1;
    check("stall_valid", 32'(rd_valid), 1);
    check("stall_data", 32'(rd_data), 32'h05A);
    check("stall_pad", 32'(rd_pad), 0);
    rd_req = 1'b0;
    // Main stream: directed head then random reads/aligns running past the end
    rst_n = 1'b0;
    src_len = 120; src_idx = 0;
    for (int i = 0; i < 120; i++) src[i] = 8'($urandom);
    src[0] = 8'hA5; src[1] = 8'h3C; src[2] = 8'hFF;
    release_dut();
    do_read(4, "rd4", d);
    check("rd4_const", 32'(d), 32'h00A);
    do_read(9, "rd9", d);
    check("rd9_const", 32'(d), 32'h0A7);
    check("rd9_bitpos_const", bit_pos, 13);
    do_align("align1");
    check("align1_const", bit_pos, 16);
    do_read(8, "rd8", d);
    check("rd8_const", 32'(d), 32'h0FF);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) do_align("rnd_align");
      else do_read(int'($urandom_range(1, 16)), "rnd_rd", d);
    end
    check("main_eos", 32'(eos), 1);
    // Short stream ending in padded read
    rst_n = 1'b0;
    src_len = 2; src_idx = 0; src[0] = 8'h12; src[1] = 8'h34;
    release_dut();
    do_read(16, "eos16", d);
    check("eos16_const", 32'(d), 32'h1234);
    check("eos16_eos", 32'(eos), 1);
    do_read(4, "pad4", d);
    check("pad4_pad_const", 32'(rd_pad), 1);
    check("pad4_bitpos_const", bit_pos, 20);
    // Asynchronous reset in the middle of a read
    rst_n = 1'b0;
    src_len = 40; src_idx = 0;
    for (int i = 0; i < 40; i++) src[i] = 8'($urandom);
    release_dut();
    do_read(8, "pre_rst8", d);
    do_read(9, "pre_rst9", d);
    rd_num = 5'd16;
    rd_req = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rd_data", 32'(rd_data), 0);
    check("async_rd_valid", 32'(rd_valid), 0);
    check("async_rd_pad", 32'(rd_pad), 0);
    check("async_bit_pos", bit_pos, 0);
    check("async_eos", 32'(eos), 0);
    release_dut();
    first_byte = base / 8;
    do_read(8, "post_rst8", d);
    check("post_rst_next_byte", 32'(d), 32'(src[8'(first_byte)]));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cabac_bit_fetcher.md
Name: cabac_bit_fetcher

Overview:
- Sits directly downstream of the byte-stream source. Consumes its byte/data_ready handshake and feeds the VVC arithmetic decoding engine.
- Buffers bytes MSB-first in a shift register and serves variable-length bit reads of 1..MAX_RD bits, e.g. 9-bit ivlOffset init and renormalisation refills.
- Supports byte alignment and zero-padded reads past end of stream.

Parameters:
- BUF_W, 32, bit-buffer width; must be a multiple of 8 and >= MAX_RD+8.
- MAX_RD, 16, maximum bits returned per read.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- byte_in  input  8  current byte from the upstream source.
- byte_valid  input  1  upstream data_ready; byte_in holds a valid byte.
- byte_req  output  1  consume request; a byte is taken at the posedge where byte_req && byte_valid.
- rd_req  input  1  bit-read request; held with rd_num stable until rd_valid.
- rd_num  input  5  bits requested, 1..MAX_RD; 0 or >MAX_RD is illegal.
- align_req  input  1  single-cycle pulse; discard bits up to the next byte boundary.
- rd_data  output  MAX_RD  read result, right-aligned, upper bits zero.
- rd_valid  output  1  one-cycle pulse; rd_data is valid.
- rd_pad  output  1  valid with rd_valid; result contained zero padding past end of stream.
- bit_pos  output  32  total bits consumed since reset (reads plus alignment discards).
- eos  output  1  end of stream latched.

Behaviour:
- Reset (async, rst_n low): buffer cleared, count=0, bit_pos=0, rd_data=0, rd_valid=0, rd_pad=0, eos=0, seen=0.
- byte_req is combinational: (count <= BUF_W-8) && !eos. It never depends on rd_req.
- Fill: on posedge with byte_req && byte_valid, append byte_in immediately below the valid bits; count += 8; seen <= 1.
- EOS: if seen && !byte_valid, eos <= 1 and stays set until reset.
  - The source drops data_ready permanently at end of file, so this marks true end of stream.
  - Before the first byte arrives (seen=0), byte_valid low is a stall, not EOS.
- Read accept: posedge with rd_req && !rd_valid && !align_req && (count >= rd_num || eos).
  - rd_data <= top rd_num valid bits, right-aligned.
  - Shift those bits out; count -= rd_num; bit_pos += rd_num; rd_valid <= 1 for one cycle.
  - Latency: rd_valid is 1 cycle after accept. At most one accept per 2 cycles, because !rd_valid gates the request the requester is still holding.
- Underrun at eos: if count < rd_num, missing LSBs are 0, count <= 0, bit_pos += rd_num, rd_pad <= 1. Otherwise rd_pad <= 0.
- Stall: if count < rd_num and !eos, the request waits with no timeout.
- Align: on an align_req pulse, discard r = bit_pos mod 8 ? 8-(bit_pos mod 8) : 0 bits, provided count >= r.
  - Updates: count -= r; bit_pos += r.
  - If count < r and !eos, align is held internally as pending and executes as soon as count >= r.
  - If count < r and eos, count <= 0 and bit_pos += r.
  - While align is pending or pulsed, rd_req is not accepted (align has priority).
- Simultaneous fill and read/align in the same cycle:
  - Apply the shift-out first, then append the byte at the new count position.
  - Net count = count - n + 8. No bit is lost or duplicated.
- count is never allowed to exceed BUF_W; byte_req guarantees this.
- Illegal rd_num: 0 or >MAX_RD is treated as MAX_RD. Assertion in simulation.
- Reset mid-operation: all state cleared, including any pending read or align. The upstream source has no reset and continues from its next byte.

Test Plan:
- Bytes A5,3C,FF,…; read 4 then read 9 -> rd_data=0x00A, then 0x0A7; bit_pos=13; rd_pad=0 both.
- Continue: align_req -> bit_pos=16 (3 bits discarded); read 8 -> rd_data=0x0FF.
- Stream of 12,34 then byte_valid low forever: read 16 -> 0x1234, rd_pad=0, eos=1. Read 4 -> 0x0, rd_pad=1, bit_pos=20.
- Hold byte_valid low from reset with rd_req=1, rd_num=8 for 50 cycles -> no rd_valid, eos=0. Then present 0x5A -> rd_valid 2 cycles after the byte is taken, rd_data=0x05A.
- count=24, read 8 while a byte is taken in the same cycle -> count stays 24. The read returns the oldest 8 bits, and the subsequent 24 bits match the input order exactly.
- Assert rst_n low mid-read (rd_req pending, count=17) -> all outputs 0 immediately. After release, the first read returns the next upstream byte.
